// File: rtl/registros_etapas_fd_de.sv
// Front-end pipeline registers: PC, IF/ID and ID/EX with stall/flush handling,
// per-stage valid tags and saturating stall/redirect performance counters.
module registros_etapas_fd_de #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     CTRL_W    = 12,
  parameter int unsigned     CNT_W     = 16,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              FlushE,
  input  logic [XLEN-1:0]   PCNextF_i,
  input  logic [31:0]       InstrF_i,
  input  logic [XLEN-1:0]   PCPlus4F_i,
  input  logic [XLEN-1:0]   RD1D_i,
  input  logic [XLEN-1:0]   RD2D_i,
  input  logic [XLEN-1:0]   ImmExtD_i,
  input  logic [4:0]        Rs1D_i,
  input  logic [4:0]        Rs2D_i,
  input  logic [4:0]        RdD_i,
  input  logic [CTRL_W-1:0] CtrlD_i,
  output logic [XLEN-1:0]   PCF_o,
  output logic [31:0]       InstrD_o,
  output logic [XLEN-1:0]   PCD_o,
  output logic [XLEN-1:0]   PCPlus4D_o,
  output logic              ValidD_o,
  output logic [XLEN-1:0]   RD1E_o,
  output logic [XLEN-1:0]   RD2E_o,
  output logic [XLEN-1:0]   ImmExtE_o,
  output logic [XLEN-1:0]   PCE_o,
  output logic [XLEN-1:0]   PCPlus4E_o,
  output logic [4:0]        Rs1E_o,
  output logic [4:0]        Rs2E_o,
  output logic [4:0]        RdE_o,
  output logic [CTRL_W-1:0] CtrlE_o,
  output logic              ValidE_o,
  output logic [CNT_W-1:0]  StallCnt_o,
  output logic [CNT_W-1:0]  FlushCnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Fetch PC: advances unless fetch is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      PCF_o <= RESET_PC;
    end else if (!StallF) begin
      PCF_o <= PCNextF_i;
    end
  end

  // IF/ID register: flush beats stall, stall beats load.
  always_ff @(posedge clk) begin
    if (reset || FlushD) begin
      InstrD_o   <= NOP_INSTR;
      PCD_o      <= '0;
      PCPlus4D_o <= '0;
      ValidD_o   <= 1'b0;
    end else if (!StallD) begin
      InstrD_o   <= InstrF_i;
      PCD_o      <= PCF_o;
      PCPlus4D_o <= PCPlus4F_i;
      ValidD_o   <= 1'b1;
    end
  end

  // ID/EX register: never holds; a flush inserts an all-zero bubble.
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      RD1E_o     <= '0;
      RD2E_o     <= '0;
      ImmExtE_o  <= '0;
      PCE_o      <= '0;
      PCPlus4E_o <= '0;
      Rs1E_o     <= '0;
      Rs2E_o     <= '0;
      RdE_o      <= '0;
      CtrlE_o    <= '0;
      ValidE_o   <= 1'b0;
    end else begin
      RD1E_o     <= RD1D_i;
      RD2E_o     <= RD2D_i;
      ImmExtE_o  <= ImmExtD_i;
      PCE_o      <= PCD_o;
      PCPlus4E_o <= PCPlus4D_o;
      Rs1E_o     <= Rs1D_i;
      Rs2E_o     <= Rs2D_i;
      RdE_o      <= RdD_i;
      CtrlE_o    <= CtrlD_i;
      ValidE_o   <= ValidD_o;
    end
  end

  // Saturating counters of decode-stall and decode-flush cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      StallCnt_o <= '0;
      FlushCnt_o <= '0;
    end else begin
      if (StallD && (StallCnt_o != CNT_MAX)) begin
        StallCnt_o <= StallCnt_o + CNT_W'(1);
      end
      if (FlushD && (FlushCnt_o != CNT_MAX)) begin
        FlushCnt_o <= FlushCnt_o + CNT_W'(1);
      end
    end
  end

endmodule
